// File: rtl/module_timer_pkg.sv
// Shared types for the down-counting timer: FSM state encoding and default width.
package module_timer_pkg;

    localparam int DEFAULT_COUNTER_WIDTH = 16;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } timer_state_t;

endpackage

// File: rtl/module_timer_down.sv
// Loadable down-counting timer with one-shot and auto-reload modes.
// Expiry is reported as a level (zero/done) and a registered one-cycle pulse (zero_pulse).
module module_timer_down
    import module_timer_pkg::*;
#(
    parameter int COUNTER_WIDTH = DEFAULT_COUNTER_WIDTH
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     en,
    input  logic                     start,
    input  logic                     stop,
    input  logic                     auto_reload,
    input  logic [COUNTER_WIDTH-1:0] load,
    output logic [COUNTER_WIDTH-1:0] val,
    output logic                     zero,
    output logic                     zero_pulse,
    output logic                     busy,
    output logic                     done
);

    timer_state_t             state;
    timer_state_t             state_next;
    logic [COUNTER_WIDTH-1:0] val_next;
    logic [COUNTER_WIDTH-1:0] reload_q;
    logic [COUNTER_WIDTH-1:0] reload_next;
    logic                     mode_q;
    logic                     mode_next;
    logic                     zero_pulse_next;

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= IDLE;
            val        <= '0;
            reload_q   <= '0;
            mode_q     <= 1'b0;
            zero_pulse <= 1'b0;
        end else begin
            state      <= state_next;
            val        <= val_next;
            reload_q   <= reload_next;
            mode_q     <= mode_next;
            zero_pulse <= zero_pulse_next;
        end
    end

    // Priority: start, then stop, then an en tick while running.
    always_comb begin
        state_next      = state;
        val_next        = val;
        reload_next     = reload_q;
        mode_next       = mode_q;
        zero_pulse_next = 1'b0;
        if (start) begin
            val_next        = load;
            reload_next     = load;
            mode_next       = auto_reload;
            state_next      = RUN;
            zero_pulse_next = (load == '0);
        end else if (stop) begin
            state_next = IDLE;
        end else if (state == RUN && en) begin
            if (val != '0) begin
                val_next        = val - COUNTER_WIDTH'(1);
                zero_pulse_next = (val == COUNTER_WIDTH'(1));
            end else if (mode_q) begin
                val_next        = reload_q;
                zero_pulse_next = (reload_q == '0);
            end else begin
                state_next = DONE;
            end
        end
    end

    always_comb begin
        busy = (state == RUN);
        done = (state == DONE);
        zero = (state != IDLE) && (val == '0);
    end

    a_zero_means_val_zero: assert property (@(posedge clk) disable iff (reset)
        zero |-> (val == '0));
    a_pulse_single: assert property (@(posedge clk) disable iff (reset)
        (zero_pulse && !en && !start) |=> !zero_pulse);
    a_busy_not_done: assert property (@(posedge clk) disable iff (reset)
        busy |-> !done);

endmodule

// File: tb/tb_module_timer_down.sv
// Directed bench for module_timer_down; each task covers one scenario with inline checks.
module tb_module_timer_down;

    localparam int W = 16;

    logic         clk = 1'b0;
    logic         reset;
    logic         en;
    logic         start;
    logic         stop;
    logic         auto_reload;
    logic [W-1:0] load;
    logic [W-1:0] val;
    logic         zero;
    logic         zero_pulse;
    logic         busy;
    logic         done;

    int total = 0;
    int bad   = 0;

    // Packed observation: {val, zero, zero_pulse, busy, done}
    logic [W+3:0] obs;
    assign obs = {val, zero, zero_pulse, busy, done};

    always #5 clk = ~clk;

    module_timer_down #(.COUNTER_WIDTH(W)) dut (
        .clk         (clk),
        .reset       (reset),
        .en          (en),
        .start       (start),
        .stop        (stop),
        .auto_reload (auto_reload),
        .load        (load),
        .val         (val),
        .zero        (zero),
        .zero_pulse  (zero_pulse),
        .busy        (busy),
        .done        (done)
    );

    // Inputs change 1 time unit after the edge; outputs are sampled at that same point.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        logic [W+3:0] exp;
        reset = 1'b1; en = 1'b0; start = 1'b0; stop = 1'b0;
        auto_reload = 1'b0; load = '0;
        tick();
        tick();
        exp = {16'd0, 1'b0, 1'b0, 1'b0, 1'b0};
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL reset_state: got %h want %h", obs, exp);
        end
        reset = 1'b0;
        tick();
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL reset_idle_hold: got %h want %h", obs, exp);
        end
    endtask

    task automatic test_one_shot();
        logic [W+3:0] exp;
        load = 16'd3; auto_reload = 1'b0; start = 1'b1;
        tick();
        start = 1'b0;
        exp = {16'd3, 1'b0, 1'b0, 1'b1, 1'b0};
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL oneshot_load: got %h want %h", obs, exp);
        end
        // en every 2nd clock: 3 -> 2 -> 1 -> 0
        for (int i = 2; i >= 0; i--) begin
            en = 1'b1;
            tick();
            en = 1'b0;
            exp = {W'(i), (i == 0), (i == 0), 1'b1, 1'b0};
            total++;
            if (obs !== exp) begin
                bad++;
                $display("FAIL oneshot_dec%0d: got %h want %h", i, obs, exp);
            end
            tick();
            exp = {W'(i), (i == 0), 1'b0, 1'b1, 1'b0};
            total++;
            if (obs !== exp) begin
                bad++;
                $display("FAIL oneshot_gap%0d: got %h want %h", i, obs, exp);
            end
        end
        en = 1'b1;
        tick();
        exp = {16'd0, 1'b1, 1'b0, 1'b0, 1'b1};
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL oneshot_done: got %h want %h", obs, exp);
        end
        tick();
        tick();
        en = 1'b0;
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL oneshot_no_underflow: got %h want %h", obs, exp);
        end
    endtask

    task automatic test_auto_reload();
        logic [W+3:0] exp;
        logic [W-1:0] exp_val [7];
        logic         exp_zp  [7];
        exp_val = '{16'd1, 16'd0, 16'd2, 16'd1, 16'd0, 16'd2, 16'd1};
        exp_zp  = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
        load = 16'd2; auto_reload = 1'b1; start = 1'b1;
        tick();
        start = 1'b0;
        auto_reload = 1'b0;
        exp = {16'd2, 1'b0, 1'b0, 1'b1, 1'b0};
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL auto_load: got %h want %h", obs, exp);
        end
        en = 1'b1;
        for (int i = 0; i < 7; i++) begin
            tick();
            exp = {exp_val[i], (exp_val[i] == '0), exp_zp[i], 1'b1, 1'b0};
            total++;
            if (obs !== exp) begin
                bad++;
                $display("FAIL auto_step%0d: got %h want %h", i, obs, exp);
            end
        end
        en = 1'b0;
    endtask

    task automatic test_zero_load();
        logic [W+3:0] exp;
        load = 16'd0; auto_reload = 1'b1; start = 1'b1;
        tick();
        start = 1'b0;
        exp = {16'd0, 1'b1, 1'b1, 1'b1, 1'b0};
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL zero_load_start: got %h want %h", obs, exp);
        end
        en = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            total++;
            if (obs !== exp) begin
                bad++;
                $display("FAIL zero_load_tick%0d: got %h want %h", i, obs, exp);
            end
        end
        en = 1'b0;
        tick();
        exp = {16'd0, 1'b1, 1'b0, 1'b1, 1'b0};
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL zero_load_idle_en: got %h want %h", obs, exp);
        end
    endtask

    task automatic test_stop_start();
        logic [W+3:0] exp;
        load = 16'd9; auto_reload = 1'b0; start = 1'b1;
        tick();
        start = 1'b0;
        en = 1'b1;
        repeat (4) tick();
        en = 1'b0;
        exp = {16'd5, 1'b0, 1'b0, 1'b1, 1'b0};
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL stop_pre: got %h want %h", obs, exp);
        end
        stop = 1'b1;
        tick();
        stop = 1'b0;
        exp = {16'd5, 1'b0, 1'b0, 1'b0, 1'b0};
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL stop_idle: got %h want %h", obs, exp);
        end
        en = 1'b1;
        tick();
        tick();
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL stop_en_ignored: got %h want %h", obs, exp);
        end
        load = 16'd4; start = 1'b1; stop = 1'b1;
        tick();
        start = 1'b0; stop = 1'b0; en = 1'b0;
        exp = {16'd4, 1'b0, 1'b0, 1'b1, 1'b0};
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL start_over_stop: got %h want %h", obs, exp);
        end
    endtask

    task automatic test_reset_mid_run();
        logic [W+3:0] exp;
        load = 16'd9; auto_reload = 1'b1; start = 1'b1;
        tick();
        start = 1'b0;
        en = 1'b1;
        repeat (3) tick();
        en = 1'b0;
        exp = {16'd6, 1'b0, 1'b0, 1'b1, 1'b0};
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL midrun_pre: got %h want %h", obs, exp);
        end
        reset = 1'b1; en = 1'b1;
        tick();
        reset = 1'b0; en = 1'b0;
        exp = {16'd0, 1'b0, 1'b0, 1'b0, 1'b0};
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL midrun_reset: got %h want %h", obs, exp);
        end
        load = 16'd2; auto_reload = 1'b0; start = 1'b1;
        tick();
        start = 1'b0;
        en = 1'b1;
        tick();
        tick();
        en = 1'b0;
        exp = {16'd0, 1'b1, 1'b1, 1'b1, 1'b0};
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL midrun_resume: got %h want %h", obs, exp);
        end
    endtask

    initial begin
        test_reset();
        test_one_shot();
        test_auto_reload();
        test_zero_load();
        test_stop_start();
        test_reset_mid_run();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
